// File: rtl/icache_pkg.sv
// icache_pkg: shared definitions for the direct-mapped instruction cache.
//   - refill FSM state encoding
//   - TileLink-UL opcode used for refills
//   - address field widths and cache line field positions
package icache_pkg;

    typedef enum logic [1:0] {
        StCache = 2'd0,
        StAddr  = 2'd1,
        StData  = 2'd2
    } state_e;

    localparam logic [2:0] TL_GET = 3'd4;

    localparam int unsigned Lines     = 32;
    localparam int unsigned LineBytes = 8;
    localparam int unsigned IdxW      = 5;
    localparam int unsigned OffW      = 3;
    localparam int unsigned TagW      = 24;

    // Line layout: {valid, tag[23:0], data[63:0]}
    localparam int unsigned LineDataLsb  = 0;
    localparam int unsigned LineDataMsb  = 63;
    localparam int unsigned LineTagLsb   = 64;
    localparam int unsigned LineTagMsb   = 87;
    localparam int unsigned LineValidBit = 88;
    localparam int unsigned LineW        = 89;

endpackage

// File: rtl/dff_ar.sv
// dff_ar: parameterised-width register with asynchronous active-high reset.
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous reset, active-high; loads ResetVal
//   d_i    - next value
//   q_o    - registered value
module dff_ar #(
    parameter int unsigned       Width    = 1,
    parameter logic [Width-1:0]  ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_o <= ResetVal;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/icache_dbg_mon.sv
// icache_dbg_mon: simulation trace monitor for icache_dm, built only when
// ICACHE_DBG_EN is defined. Prints one line per clock whenever a refill is in
// flight or the fetch PC changed.
// Ports: clk_i/rst_i plus read-only copies of the cache's lookup, FSM and bus
// signals (all inputs, no outputs).
`ifdef ICACHE_DBG_EN
module icache_dbg_mon
    import icache_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [63:0]      pc_i,
    input  state_e           state_i,
    input  logic [LineW-1:0] line_i,
    input  logic [LineW-1:0] bh_line_i,
    input  logic [1:0]       req_bmp_i,
    input  logic             inst_valid_i,
    input  logic [31:0]      inst_i,
    input  logic             page_fault_i,
    input  logic             invalid_i,
    input  logic             request_i,
    input  logic             a_valid_i,
    input  logic             a_ready_i,
    input  logic [63:0]      a_address_i,
    input  logic             d_valid_i,
    input  logic [63:0]      d_data_i
);

    logic [63:0] pc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_i;
            if (state_i != StCache || pc_i != pc_q) begin
                $display("icache: pc=%h st=%0d line=%h bh=%h bmp=%b iv=%b inst=%h pf=%b inv=%b req=%b a_v=%b a_r=%b a_addr=%h d_v=%b d=%h",
                         pc_i, state_i, line_i, bh_line_i, req_bmp_i, inst_valid_i, inst_i,
                         page_fault_i, invalid_i, request_i, a_valid_i, a_ready_i,
                         a_address_i, d_valid_i, d_data_i);
            end
        end
    end

endmodule
`endif

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache, 32 lines x 8 bytes,
// refilled over a TileLink-UL master port with 8-byte Get requests.
// Returns 32-bit or 16-bit instructions, including ones straddling two lines.
// Optional: define ICACHE_DBG_EN to instantiate the icache_dbg_mon trace monitor.
// Ports:
//   clk_i, rst_i           - clock, asynchronous active-high reset
//   invalid_i              - flush all lines and abort a pending refill
//   page_fault_i           - translation fault, suppresses/aborts the request
//   pc_i                   - fetch address (lookup uses bits 31:0)
//   inst_valid_o, inst_comp_o, inst_o - fetched instruction
//   request_o              - refill in progress
//   a_*                    - TileLink channel A (Get requests)
//   d_*                    - TileLink channel D (refill data)
module icache_dm
    import icache_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        invalid_i,
    input  logic        page_fault_i,
    input  logic [63:0] pc_i,
    output logic        inst_valid_o,
    output logic        inst_comp_o,
    output logic [31:0] inst_o,
    output logic        request_o,
    output logic        a_valid_o,
    input  logic        a_ready_i,
    output logic [2:0]  a_opcode_o,
    output logic [2:0]  a_size_o,
    output logic [3:0]  a_source_o,
    output logic [7:0]  a_mask_o,
    output logic [63:0] a_address_o,
    input  logic        d_valid_i,
    output logic        d_ready_o,
    input  logic [63:0] d_data_i
);

    logic [LineW-1:0] lines_q [Lines];

    state_e      state_q, state_d;
    logic [1:0]  state_raw;
    logic [63:0] req_addr_q, req_addr_d;
    logic [1:0]  req_bmp_q, req_bmp_d;

    // Primary lookup
    logic [TagW-1:0]  tag;
    logic [IdxW-1:0]  idx;
    logic [OffW-1:0]  off;
    logic [LineW-1:0] line;
    logic [63:0]      data;
    logic             hit;
    logic             crossed;

    // Back-half lookup for instructions straddling into the next line
    logic [31:0]      bh_pc;
    logic [TagW-1:0]  bh_tag;
    logic [IdxW-1:0]  bh_idx;
    logic [LineW-1:0] bh_line;
    logic             hit_rest;

    logic [63:0] shifted;
    logic        miss;
    logic        fill_en;
    logic [63:0] fill_addr;
    logic        last_req;

    assign tag  = pc_i[31:8];
    assign idx  = pc_i[7:3];
    assign off  = pc_i[2:0];
    assign line = lines_q[idx];
    assign data = line[LineDataMsb:LineDataLsb];
    assign hit  = line[LineValidBit] & (line[LineTagMsb:LineTagLsb] == tag);

    // Uses possibly stale data on a miss; this lets a cold crossed fetch request both halves.
    assign crossed = (off == 3'd6) & (data[49:48] == 2'b11);

    assign bh_pc    = {pc_i[31:3] + 29'd1, 3'b000};
    assign bh_tag   = bh_pc[31:8];
    assign bh_idx   = bh_pc[7:3];
    assign bh_line  = lines_q[bh_idx];
    assign hit_rest = bh_line[LineValidBit] & (bh_line[LineTagMsb:LineTagLsb] == bh_tag);

    assign shifted = data >> {off, 3'b000};

    assign inst_valid_o = ~invalid_i & hit & (~crossed | hit_rest);

    always_comb begin
        inst_o = 32'h0000_0001;
        if (inst_valid_o) begin
            if (crossed) begin
                inst_o = {bh_line[15:0], data[63:48]};
            end else begin
                inst_o = shifted[31:0];
            end
        end
    end

    assign inst_comp_o = (inst_o[1:0] != 2'b11);

    assign miss      = ~hit | (crossed & ~hit_rest);
    assign last_req  = (req_bmp_q == 2'b01) | (req_bmp_q == 2'b10);
    assign fill_addr = req_bmp_q[0] ? req_addr_q : req_addr_q + 64'd8;

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        req_bmp_d  = req_bmp_q;
        fill_en    = 1'b0;
        unique case (state_q)
            StCache: begin
                if (!invalid_i && miss) begin
                    req_addr_d = {pc_i[63:3], 3'b000};
                    req_bmp_d  = {crossed & ~hit_rest, ~hit};
                    state_d    = StAddr;
                end
            end
            StAddr: begin
                if (invalid_i || page_fault_i) begin
                    req_addr_d = '0;
                    req_bmp_d  = '0;
                    state_d    = StCache;
                end else if (a_ready_i) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (invalid_i) begin
                    req_addr_d = '0;
                    req_bmp_d  = '0;
                    state_d    = StCache;
                end else if (d_valid_i) begin
                    fill_en = 1'b1;
                    if (last_req) begin
                        req_bmp_d = '0;
                        state_d   = StCache;
                    end else begin
                        req_bmp_d[0] = 1'b0;
                        state_d      = StAddr;
                    end
                end
            end
            default: state_d = StCache;
        endcase
    end

    dff_ar #(
        .Width    (2),
        .ResetVal (2'd0)
    ) u_state_reg (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (state_d),
        .q_o   (state_raw)
    );

    assign state_q = state_e'(state_raw);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_addr_q <= '0;
            req_bmp_q  <= '0;
            for (int i = 0; i < Lines; i++) begin
                lines_q[i] <= '0;
            end
        end else begin
            req_addr_q <= req_addr_d;
            req_bmp_q  <= req_bmp_d;
            // Flush wins over a fill landing in the same cycle
            if (invalid_i) begin
                for (int i = 0; i < Lines; i++) begin
                    lines_q[i][LineValidBit] <= 1'b0;
                end
            end else if (fill_en) begin
                lines_q[fill_addr[7:3]] <= {1'b1, fill_addr[31:8], d_data_i};
            end
        end
    end

    assign a_valid_o   = (state_q == StAddr) & ~page_fault_i;
    assign a_address_o = req_bmp_q[0] ? req_addr_q :
                         req_bmp_q[1] ? req_addr_q + 64'd8 : 64'd0;
    assign request_o   = ((state_q == StAddr) & ~invalid_i & ~page_fault_i) |
                         (state_q == StData);

    assign a_opcode_o = TL_GET;
    assign a_size_o   = 3'd3;
    assign a_source_o = 4'd0;
    assign a_mask_o   = 8'hFF;
    assign d_ready_o  = 1'b1;

`ifdef ICACHE_DBG_EN
    icache_dbg_mon u_dbg_mon (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pc_i         (pc_i),
        .state_i      (state_q),
        .line_i       (line),
        .bh_line_i    (bh_line),
        .req_bmp_i    (req_bmp_q),
        .inst_valid_i (inst_valid_o),
        .inst_i       (inst_o),
        .page_fault_i (page_fault_i),
        .invalid_i    (invalid_i),
        .request_i    (request_o),
        .a_valid_i    (a_valid_o),
        .a_ready_i    (a_ready_i),
        .a_address_i  (a_address_o),
        .d_valid_i    (d_valid_i),
        .d_data_i     (d_data_i)
    );
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: reset, cold miss, compressed hits, crossed
// single/double misses, page-fault abort and flush during refill.
module tb_icache_dm;

    logic        clk;
    logic        rst;
    logic        invalid;
    logic        page_fault;
    logic [63:0] pc;
    logic        inst_valid;
    logic        inst_comp;
    logic [31:0] inst;
    logic        request;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_size;
    logic [3:0]  a_source;
    logic [7:0]  a_mask;
    logic [63:0] a_address;
    logic        d_valid;
    logic        d_ready;
    logic [63:0] d_data;

    int vectors;
    int miscompares;

    icache_dm dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .invalid_i    (invalid),
        .page_fault_i (page_fault),
        .pc_i         (pc),
        .inst_valid_o (inst_valid),
        .inst_comp_o  (inst_comp),
        .inst_o       (inst),
        .request_o    (request),
        .a_valid_o    (a_valid),
        .a_ready_i    (a_ready),
        .a_opcode_o   (a_opcode),
        .a_size_o     (a_size),
        .a_source_o   (a_source),
        .a_mask_o     (a_mask),
        .a_address_o  (a_address),
        .d_valid_i    (d_valid),
        .d_ready_o    (d_ready),
        .d_data_i     (d_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serve one Get: wait (bounded) for a_valid, check its address, then return data.
    // Entered and left at a negedge with d_valid low.
    task automatic serve(input string name, input logic [63:0] exp_addr, input logic [63:0] data);
        int waited = 0;
        while (!a_valid && waited < 10) begin
            @(negedge clk);
            #1;
            waited++;
        end
        vectors++;
        if (!a_valid) begin
            miscompares++;
            $display("FAIL %s: a_valid never rose, got %b want 1", name, a_valid);
            return;
        end
        vectors++;
        if (a_address !== exp_addr) begin
            miscompares++;
            $display("FAIL %s addr: got %h want %h", name, a_address, exp_addr);
        end
        @(negedge clk);
        vectors++;
        if (request !== 1'b1 || a_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s data-phase: request/a_valid got %b%b want 10", name, request, a_valid);
        end
        d_valid = 1'b1;
        d_data  = data;
        @(negedge clk);
        d_valid = 1'b0;
        d_data  = '0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; invalid = 1'b0; page_fault = 1'b0; pc = '0;
        a_ready = 1'b1; d_valid = 1'b0; d_data = '0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (inst_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset inst_valid: got %b want 0", inst_valid);
        end
        vectors++;
        if (inst !== 32'h1 || inst_comp !== 1'b1) begin
            miscompares++; $display("FAIL reset inst: got %h/%b want 00000001/1", inst, inst_comp);
        end
        vectors++;
        if (request !== 1'b0 || a_valid !== 1'b0 || a_address !== 64'd0) begin
            miscompares++;
            $display("FAIL reset bus: req=%b a_valid=%b addr=%h want 0 0 0", request, a_valid, a_address);
        end
        vectors++;
        if (a_opcode !== 3'd4 || a_size !== 3'd3 || a_source !== 4'd0 || a_mask !== 8'hFF || d_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset consts: op=%0d size=%0d src=%0d mask=%h d_ready=%b want 4 3 0 ff 1",
                     a_opcode, a_size, a_source, a_mask, d_ready);
        end
        invalid = 1'b1;  // hold in CACHE until the first test picks a pc
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cold_miss();
        pc = 64'h1000;
        invalid = 1'b0;
        #1;
        vectors++;
        if (inst_valid !== 1'b0) begin
            miscompares++; $display("FAIL cold pre-fill inst_valid: got %b want 0", inst_valid);
        end
        serve("cold", 64'h1000, 64'h00000013_00100093);
        vectors++;
        if (inst_valid !== 1'b1 || inst !== 32'h00100093 || inst_comp !== 1'b0) begin
            miscompares++;
            $display("FAIL cold hit: got v=%b inst=%h c=%b want 1 00100093 0", inst_valid, inst, inst_comp);
        end
        vectors++;
        if (request !== 1'b0) begin
            miscompares++; $display("FAIL cold request: got %b want 0", request);
        end
    endtask

    task automatic test_compressed_hit();
        @(negedge clk);
        pc = 64'h1002;
        #1;
        vectors++;
        if (inst_valid !== 1'b1 || inst !== 32'h00130010 || inst_comp !== 1'b1) begin
            miscompares++;
            $display("FAIL comp 1002: got v=%b inst=%h c=%b want 1 00130010 1", inst_valid, inst, inst_comp);
        end
        @(negedge clk);
        pc = 64'h1004;
        #1;
        vectors++;
        if (inst_valid !== 1'b1 || inst !== 32'h00000013 || inst_comp !== 1'b0) begin
            miscompares++;
            $display("FAIL comp 1004: got v=%b inst=%h c=%b want 1 00000013 0", inst_valid, inst, inst_comp);
        end
    endtask

    task automatic test_crossed_miss();
        @(negedge clk);
        pc = 64'h2000;
        #1;
        serve("cross-pre", 64'h2000, 64'h0093_0000_1234_5678);
        vectors++;
        if (inst_valid !== 1'b1 || inst !== 32'h12345678) begin
            miscompares++; $display("FAIL cross-pre hit: got v=%b inst=%h want 1 12345678", inst_valid, inst);
        end
        pc = 64'h2006;
        #1;
        vectors++;
        if (inst_valid !== 1'b0) begin
            miscompares++; $display("FAIL cross miss inst_valid: got %b want 0", inst_valid);
        end
        @(negedge clk);
        #1;
        serve("cross", 64'h2008, 64'h1111_2222_3333_4457);
        vectors++;
        if (inst_valid !== 1'b1 || inst !== 32'h44570093 || inst_comp !== 1'b0) begin
            miscompares++;
            $display("FAIL cross hit: got v=%b inst=%h c=%b want 1 44570093 0", inst_valid, inst, inst_comp);
        end
        vectors++;
        if (request !== 1'b0) begin
            miscompares++; $display("FAIL cross single-get request: got %b want 0", request);
        end
    endtask

    task automatic test_double_miss();
        @(negedge clk);
        invalid = 1'b1;
        #1;
        vectors++;
        if (inst_valid !== 1'b0 || inst !== 32'h1) begin
            miscompares++;
            $display("FAIL invalid gating: got v=%b inst=%h want 0 00000001", inst_valid, inst);
        end
        @(negedge clk);
        invalid = 1'b0;
        #1;
        // Stale line 0x2000 still has 11 in bits 49:48, so both halves are requested
        serve("dbl-first", 64'h2000, 64'hC0F3_0000_0000_0000);
        serve("dbl-second", 64'h2008, 64'h0000_0000_0000_8765);
        vectors++;
        if (inst_valid !== 1'b1 || inst !== 32'h8765C0F3) begin
            miscompares++; $display("FAIL dbl hit: got v=%b inst=%h want 1 8765c0f3", inst_valid, inst);
        end
        vectors++;
        if (request !== 1'b0) begin
            miscompares++; $display("FAIL dbl request: got %b want 0", request);
        end
    endtask

    task automatic test_page_fault();
        @(negedge clk);
        a_ready = 1'b0;
        pc = 64'h3000;
        @(negedge clk);
        #1;
        vectors++;
        if (a_valid !== 1'b1 || request !== 1'b1 || a_address !== 64'h3000) begin
            miscompares++;
            $display("FAIL pf pre: a_valid=%b req=%b addr=%h want 1 1 3000", a_valid, request, a_address);
        end
        page_fault = 1'b1;
        #1;
        vectors++;
        if (a_valid !== 1'b0 || request !== 1'b0) begin
            miscompares++; $display("FAIL pf gate: a_valid=%b req=%b want 0 0", a_valid, request);
        end
        @(negedge clk);
        page_fault = 1'b0;
        a_ready = 1'b1;
        pc = 64'h2000;
        #1;
        vectors++;
        if (request !== 1'b0 || inst_valid !== 1'b1 || inst !== 32'h0) begin
            miscompares++;
            $display("FAIL pf abort: req=%b v=%b inst=%h want 0 1 00000000", request, inst_valid, inst);
        end
        pc = 64'h3000;
        #1;
        vectors++;
        if (inst_valid !== 1'b0) begin
            miscompares++; $display("FAIL pf no-fill: inst_valid got %b want 0", inst_valid);
        end
        @(negedge clk);
        #1;
        serve("pf-refill", 64'h3000, 64'h0000_0000_0000_0013);
        vectors++;
        if (inst_valid !== 1'b1 || inst !== 32'h13) begin
            miscompares++; $display("FAIL pf refill hit: v=%b inst=%h want 1 00000013", inst_valid, inst);
        end
    endtask

    task automatic test_invalid_in_data();
        int waited = 0;
        @(negedge clk);
        pc = 64'h4000;
        #1;
        while (!a_valid && waited < 10) begin
            @(negedge clk);
            #1;
            waited++;
        end
        vectors++;
        if (a_valid !== 1'b1) begin
            miscompares++; $display("FAIL inv-data a_valid: got %b want 1", a_valid);
        end
        @(negedge clk);
        invalid = 1'b1;
        d_valid = 1'b1;
        d_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        #1;
        vectors++;
        if (request !== 1'b1) begin
            miscompares++; $display("FAIL inv-data request in DATA: got %b want 1", request);
        end
        @(negedge clk);
        invalid = 1'b0;
        d_valid = 1'b0;
        d_data  = '0;
        #1;
        vectors++;
        if (inst_valid !== 1'b0 || request !== 1'b0 || a_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL inv-data discard: v=%b req=%b a_valid=%b want 0 0 0", inst_valid, request, a_valid);
        end
        pc = 64'h3000;
        #1;
        vectors++;
        if (inst_valid !== 1'b0) begin
            miscompares++; $display("FAIL inv-data flush: pc 3000 inst_valid got %b want 0", inst_valid);
        end
        pc = 64'h4000;
        #1;
        @(negedge clk);
        #1;
        serve("inv-refill", 64'h4000, 64'h0000_0000_0051_0513);
        vectors++;
        if (inst_valid !== 1'b1 || inst !== 32'h00510513) begin
            miscompares++; $display("FAIL inv refill hit: v=%b inst=%h want 1 00510513", inst_valid, inst);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_cold_miss();
        test_compressed_hit();
        test_crossed_miss();
        test_double_miss();
        test_page_fault();
        test_invalid_in_data();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
